// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO port for the RISC5 I/O space.
// Provides output latch with atomic set/clear, drive enables, two-flop input
// synchronisation, per-bit edge interrupts with mask and W1C pending bits.
// Optional input debounce is built when GPIO_DEBOUNCE_EN is defined.
module gpio_bank #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic [2:0]       regadr,
  input  logic             wr,
  input  logic             rd,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpin,
  output logic [WIDTH-1:0] gpout,
  output logic [WIDTH-1:0] gpoe,
  output logic             irq
);

  localparam logic [2:0] A_DATA  = 3'd0;
  localparam logic [2:0] A_DIR   = 3'd1;
  localparam logic [2:0] A_SET   = 3'd2;
  localparam logic [2:0] A_CLR   = 3'd3;
  localparam logic [2:0] A_IMASK = 3'd4;
  localparam logic [2:0] A_IPEND = 3'd5;
  localparam logic [2:0] A_IEDGE = 3'd6;
  localparam logic [2:0] A_OUT   = 3'd7;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_imask;
  logic [WIDTH-1:0] r_ipend;
  logic [WIDTH-1:0] r_iedge;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_fprev;

  logic             w_we;
  logic [WIDTH-1:0] w_wd;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_unused;

  assign w_we     = sel & wr;
  assign w_wd     = wdata[WIDTH-1:0];
  // Read strobe and upper write bits carry no function here.
  assign w_unused = ^{rd, wdata, DB_CYCLES};

  // Software-visible control registers: OUT (incl. set/clear), DIR, IMASK, IEDGE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out   <= '0;
      r_dir   <= '0;
      r_imask <= '0;
      r_iedge <= '0;
    end else if (w_we) begin
      case (regadr)
        A_DATA:  r_out   <= w_wd;
        A_DIR:   r_dir   <= w_wd;
        A_SET:   r_out   <= r_out | w_wd;
        A_CLR:   r_out   <= r_out & ~w_wd;
        A_IMASK: r_imask <= w_wd;
        A_IEDGE: r_iedge <= w_wd;
        default: ;
      endcase
    end
  end

  // Two-flop synchroniser plus previous filtered value for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_fprev <= '0;
    end else begin
      r_s1    <= gpin;
      r_s2    <= r_s1;
      r_fprev <= w_f;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DB_CYCLES);

  logic [WIDTH-1:0] r_f;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  // Per-bit debounce: f follows s2 only after it has differed for DB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (r_s2[i] == r_f[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
          r_f[i]   <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_f = r_f;
`else
  // Without debounce the filtered value is the synchroniser output itself.
  assign w_f = r_s2;
`endif

  assign w_rise  = w_f & ~r_fprev;
  assign w_fall  = ~w_f & r_fprev;
  assign w_event = (w_rise & ~r_iedge) | (w_fall & r_iedge);
  assign w_clr   = (w_we && (regadr == A_IPEND)) ? w_wd : '0;

  // Pending bits: edge events set, IPEND write-1 clears; a same-cycle set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ipend <= '0;
    end else begin
      r_ipend <= (r_ipend & ~w_clr) | w_event;
    end
  end

  // Combinational read mux, zero-extended to 32 bits.
  always_comb begin
    rdata = '0;
    case (regadr)
      A_DATA:  rdata = 32'(w_f);
      A_DIR:   rdata = 32'(r_dir);
      A_IMASK: rdata = 32'(r_imask);
      A_IPEND: rdata = 32'(r_ipend);
      A_IEDGE: rdata = 32'(r_iedge);
      A_OUT:   rdata = 32'(r_out);
      default: rdata = '0;
    endcase
  end

  assign gpout = r_out;
  assign gpoe  = r_dir;
  assign irq   = |(r_ipend & r_imask);

endmodule
